// File: rtl/score_tally.sv
// Round-scoring stage: samples the per-player score vector on each button press,
// keeps saturating per-player totals and a round counter, and declares the winner(s).
module score_tally #(
    parameter int CNT_W      = 4,
    parameter int TARGET     = 10,
    parameter int RND_W      = 5,
    parameter int MAX_ROUNDS = 15
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [3:0]         score,
    input  logic               score_btn,
    input  logic               new_game,
    output logic [4*CNT_W-1:0] totals,
    output logic [RND_W-1:0]   round_cnt,
    output logic               round_done,
    output logic [3:0]         winner,
    output logic               game_over
);

    typedef enum logic [1:0] {PLAY, UPDATE, CHECK, OVER} state_t;

    state_t           state, state_nxt;
    logic             btn_q, press, press_q;
    logic [3:0]       score_q, sample;
    logic [CNT_W-1:0] tot [4];
    logic             latch_en, update_en, check_en;
    logic [3:0]       hit_mask, max_mask, win_mask;
    logic [CNT_W-1:0] max_v;
    logic             win_now;

    // The press is registered together with the score it saw, so the FSM acts one
    // cycle after the rising edge of the button.
    assign press = score_btn & ~btn_q;

    for (genvar g = 0; g < 4; g++) begin : g_pack
        assign totals[CNT_W*g +: CNT_W] = tot[g];
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst || new_game) state <= PLAY;
        else                 state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        // NOTE: every combinational output gets a default first, otherwise a
        // path through the case that skips it infers a latch.
        state_nxt = state;
        case (state)
            PLAY:    if (press_q) state_nxt = UPDATE;
            UPDATE:  state_nxt = CHECK;
            CHECK:   state_nxt = win_now ? OVER : PLAY;
            default: state_nxt = OVER;
        endcase
    end

    // Output (control strobe) logic
    always_comb begin
        latch_en  = (state == PLAY) && press_q;
        update_en = (state == UPDATE);
        check_en  = (state == CHECK);
    end

    // Winner evaluation on the already-updated totals; an all-zero board ties everyone.
    always_comb begin
        hit_mask = '0;
        max_mask = '0;
        max_v    = '0;
        for (int i = 0; i < 4; i++) begin
            if (tot[i] >= CNT_W'(TARGET)) hit_mask[i] = 1'b1;
            if (tot[i] > max_v)           max_v       = tot[i];
        end
        for (int i = 0; i < 4; i++) begin
            if (tot[i] == max_v) max_mask[i] = 1'b1;
        end
        win_now  = (|hit_mask) || (round_cnt == RND_W'(MAX_ROUNDS));
        win_mask = (|hit_mask) ? hit_mask : max_mask;
    end

    // btn_q tracks the button in every state, including across new_game.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values regardless of statement order.
        if (rst) btn_q <= 1'b0;
        else     btn_q <= score_btn;
    end

    always_ff @(posedge clk) begin
        if (rst || new_game) begin
            press_q    <= 1'b0;
            score_q    <= '0;
            sample     <= '0;
            round_cnt  <= '0;
            round_done <= 1'b0;
            winner     <= '0;
            game_over  <= 1'b0;
            for (int i = 0; i < 4; i++) tot[i] <= '0;
        end else begin
            press_q    <= press;
            round_done <= update_en;
            if (press)    score_q <= score;
            if (latch_en) sample  <= score_q;
            if (update_en) begin
                for (int i = 0; i < 4; i++) begin
                    if (sample[i] && tot[i] != '1) tot[i] <= tot[i] + CNT_W'(1);
                end
                if (round_cnt != '1) round_cnt <= round_cnt + RND_W'(1);
            end
            if (check_en && win_now) begin
                winner    <= win_mask;
                game_over <= 1'b1;
            end
        end
    end

endmodule
